alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Sequencing front end for the 8-bit ALU: accepts one 16-bit R-type instruction per handshake, reads two operands from an internal 8×8 register file, and drives the ALU's `op1`/`op2`/`func` ports. It captures the ALU `result` and writes it back to the destination register. It sits between instruction fetch and the combinational ALU and is the initiator side of the ALU's operand/result interface. A debug read port exposes register contents to the bench and top level.

## Interface
- `DATA_W`, default 8: datapath and register width; must match the ALU.
- `NREGS`, default 8: register count, addressed by 3 bits; r0 reads as zero.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `instr_valid`  in  1  instruction offered.
- `instr_ready`  out  1  block can accept an instruction.
- `instr`  in  16  `[15:13]` op, `[12:10]` rd, `[9:7]` rs, `[6:4]` rt, `[7:0]` imm (LI only).
- `alu_op1`  out  8  registered operand A, from reg[rs].
- `alu_op2`  out  8  registered operand B, from reg[rt].
- `alu_func`  out  3  registered op field.
- `alu_result`  in  8  combinational ALU output.
- `done`  out  1  one-cycle pulse marking completion of the instruction.
- `illegal`  out  1  one-cycle pulse, coincident with `done`, for op 5 or 6.
- `dbg_addr`  in  3  debug register select.
- `dbg_data`  out  8  combinational reg[dbg_addr]; 0 when `dbg_addr` is 0.

## Operation
- Op encoding: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR (ALU ops); 7 LI (rd ← imm, ALU bypassed); 5 and 6 are illegal.
- FSM states:
  - IDLE: `instr_ready`=1. On `instr_valid`, latch `instr` and go to READ.
  - READ: load `alu_op1`=reg[rs], `alu_op2`=reg[rt], `alu_func`=op; go to EXEC. All ops load these registers, including LI and illegal ops.
  - EXEC: capture `alu_result` into `res_q`; for LI, `res_q`=imm; go to WB.
  - WB: write `res_q` to reg[rd] if rd≠0 and op is legal; pulse `done` (plus `illegal` when applicable); go to IDLE.
- Illegal op: no register write. The ALU still sees func 5/6 and returns 0, which is ignored.
- Writes to r0 are discarded.
- `instr` is ignored outside IDLE. The block never back-pressures while in IDLE.
- Arithmetic wraps modulo 256, with no carry or overflow output; wrap behaviour is the ALU's.

## Timing
- Reset values: all registers 0, `alu_op1`/`alu_op2`/`alu_func` 0, `done`/`illegal` 0, FSM in IDLE, `instr_ready`=1 in the first cycle after reset.
- Accept at edge T (valid & ready). READ runs in T+1, EXEC in T+2, WB in T+3 with `done` high; the register write lands at the end of T+3.
- `dbg_data` reflects the write from cycle T+4 onward. `instr_ready` returns to 1 in T+4, so peak throughput is 1 instruction per 4 cycles.
- A back-to-back dependent instruction accepted at T+4 reads the updated value, since READ occurs in T+5.
- Reset asserted in any state: abort the in-flight instruction, suppress the write and `done`, clear all state on that edge. Reset has priority over every other event.
- `alu_result` must be stable during EXEC. The ALU is purely combinational, so one cycle suffices.

## Structure
- Shared package `mips8_pkg`: op constants (OP_ADD..OP_XOR, OP_LI), FSM state encoding, instruction field positions, `DATA_W`.
- One sub-module, `mips8_regfile`:
  - two combinational read ports (rs/rt), plus a third for debug;
  - one synchronous write port;
  - r0 hardwired to zero;
  - synchronous reset to zero.
- The ALU is instantiated alongside this block at the level above, not inside it.

## Test plan
- Reset, then LI r1←0x05, LI r2←0x03 -> `done` at T+3 each; `dbg_data`(1)=0x05 and `dbg_data`(2)=0x03 from T+4.
- With r1/r2 as above, ADD r3=r1+r2 then SUB r4=r2−r1 -> r3=0x08, r4=0xFE; `alu_op1`/`alu_op2` visible as 0x05/0x03, then 0x03/0x05, during EXEC.
- LI r1←0xFF, LI r2←0x01, ADD r5 -> r5=0x00 (wrap); AND/OR/XOR of 0xF0,0x3C -> 0x30/0xFC/0xCC.
- Op 5 targeting r3 -> `illegal` and `done` pulse together; r3 unchanged. Then LI r0←0xAA -> `done` pulses, `dbg_data`(0)=0x00.
- `instr_valid` held high continuously -> accepts exactly every 4th cycle; `instr` changes during READ/EXEC/WB are ignored.
- Assert `rst` during EXEC of ADD r6 -> no `done`, r6=0, all registers 0, `instr_ready`=1 the next cycle.

Source files
------------

// File: rtl/mips8_pkg.sv
// Shared definitions for the 8-bit ALU issue front end: opcodes, FSM states,
// instruction field positions and datapath sizing.
package mips8_pkg;

    localparam int DATA_W = 8;
    localparam int NREGS  = 8;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LI  = 3'd7;

    localparam int OP_LSB  = 13;
    localparam int RD_LSB  = 10;
    localparam int RS_LSB  = 7;
    localparam int RT_LSB  = 4;
    localparam int IMM_LSB = 0;
    localparam int IMM_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_e;

    // Opcodes 5 and 6 are the only unassigned encodings.
    function automatic logic op_is_legal(input logic [2:0] op);
        return !((op == 3'd5) || (op == 3'd6));
    endfunction

endpackage

// File: rtl/mips8_regfile.sv
// Register file: two operand read ports, one debug read port and one
// synchronous write port. r0 always reads as zero.
module mips8_regfile #(
    parameter int DATA_W = mips8_pkg::DATA_W,
    parameter int NREGS  = mips8_pkg::NREGS,
    parameter int ADDR_W = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs_addr,
    output logic [DATA_W-1:0] rs_data,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rt_data,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];

    always_comb begin
        regs_d = regs_q;
        if (wr_en && (wr_addr != '0)) begin
            regs_d[wr_addr] = wr_data;
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rs_data  = (rs_addr  == '0) ? '0 : regs_q[rs_addr];
    assign rt_data  = (rt_addr  == '0) ? '0 : regs_q[rt_addr];
    assign dbg_data = (dbg_addr == '0) ? '0 : regs_q[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue sequencer for the combinational 8-bit ALU: accept, read operands,
// execute, write back. One instruction in flight, four cycles each.
module alu_issue_ctrl #(
    parameter int DATA_W = mips8_pkg::DATA_W,
    parameter int NREGS  = mips8_pkg::NREGS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       instr,
    output logic [DATA_W-1:0] alu_op1,
    output logic [DATA_W-1:0] alu_op2,
    output logic [2:0]        alu_func,
    input  logic [DATA_W-1:0] alu_result,
    output logic              done,
    output logic              illegal,
    input  logic [2:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);
    // state   | meaning
    // IDLE    | ready for a new instruction
    // READ    | operands and func loaded toward the ALU
    // EXEC    | ALU result (or LI immediate) captured
    // WB      | write-back, done/illegal pulse
    import mips8_pkg::*;

    state_e            state_q, state_d;
    logic [15:0]       instr_q, instr_d;
    logic [DATA_W-1:0] op1_q, op1_d;
    logic [DATA_W-1:0] op2_q, op2_d;
    logic [2:0]        func_q, func_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              done_q, done_d;
    logic              illegal_q, illegal_d;

    logic [2:0]        op, rd, rs, rt;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] rs_data, rt_data;
    logic              wr_en;

    assign op  = instr_q[OP_LSB +: 3];
    assign rd  = instr_q[RD_LSB +: 3];
    assign rs  = instr_q[RS_LSB +: 3];
    assign rt  = instr_q[RT_LSB +: 3];
    assign imm = DATA_W'(instr_q[IMM_LSB +: IMM_W]);

    // Reset on the same edge clears the file, so an aborted WB never lands.
    assign wr_en = (state_q == ST_WB) && op_is_legal(op) && (rd != 3'd0);

    mips8_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .rs_addr  (rs),
        .rs_data  (rs_data),
        .rt_addr  (rt),
        .rt_data  (rt_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .wr_en    (wr_en),
        .wr_addr  (rd),
        .wr_data  (res_q)
    );

    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        op1_d     = op1_q;
        op2_d     = op2_q;
        func_d    = func_q;
        res_d     = res_q;
        done_d    = 1'b0;
        illegal_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (instr_valid) begin
                    instr_d = instr;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                op1_d   = rs_data;
                op2_d   = rt_data;
                func_d  = op;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                res_d     = (op == OP_LI) ? imm : alu_result;
                done_d    = 1'b1;
                illegal_d = !op_is_legal(op);
                state_d   = ST_WB;
            end
            ST_WB: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            instr_q   <= '0;
            op1_q     <= '0;
            op2_q     <= '0;
            func_q    <= '0;
            res_q     <= '0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            op1_q     <= op1_d;
            op2_q     <= op2_d;
            func_q    <= func_d;
            res_q     <= res_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
        end
    end

    assign instr_ready = (state_q == ST_IDLE);
    assign alu_op1     = op1_q;
    assign alu_op2     = op2_q;
    assign alu_func    = func_q;
    assign done        = done_q;
    assign illegal     = illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: a table of single-instruction vectors followed by
// hand-written sequences for continuous valid and mid-instruction reset.
module tb_alu_issue_ctrl;

    logic        clk;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [7:0]  alu_op1;
    logic [7:0]  alu_op2;
    logic [2:0]  alu_func;
    logic [7:0]  alu_result;
    logic        done;
    logic        illegal;
    logic [2:0]  dbg_addr;
    logic [7:0]  dbg_data;

    int n_tests = 0;
    int n_fail  = 0;

    alu_issue_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .alu_op1     (alu_op1),
        .alu_op2     (alu_op2),
        .alu_func    (alu_func),
        .alu_result  (alu_result),
        .done        (done),
        .illegal     (illegal),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Stand-in for the external combinational ALU.
    always_comb begin
        case (alu_func)
            3'd0:    alu_result = alu_op1 + alu_op2;
            3'd1:    alu_result = alu_op1 - alu_op2;
            3'd2:    alu_result = alu_op1 & alu_op2;
            3'd3:    alu_result = alu_op1 | alu_op2;
            3'd4:    alu_result = alu_op1 ^ alu_op2;
            default: alu_result = 8'h00;
        endcase
    end

    typedef struct {
        logic [15:0] instr;
        logic [2:0]  addr;
        logic [7:0]  exp_data;
        logic        exp_ill;
        logic        chk_ops;
        logic [7:0]  exp_op1;
        logic [7:0]  exp_op2;
    } vec_t;

    vec_t vecs [16];

    function automatic logic [15:0] mk_r(input logic [2:0] op, input logic [2:0] rd,
                                         input logic [2:0] rs, input logic [2:0] rt);
        return {op, rd, rs, rt, 4'b0000};
    endfunction

    function automatic logic [15:0] mk_li(input logic [2:0] rd, input logic [7:0] imm);
        return {3'd7, rd, 2'b00, imm};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int guard = 0;
        while (!instr_ready && guard < 10) begin
            @(posedge clk); #1;
            guard++;
        end
        check("ready_wait", instr_ready, 1);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        wait_ready();
        instr       = v.instr;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        instr       = 16'hE5A5;
        check($sformatf("v%0d_read_done", idx), done, 0);
        check($sformatf("v%0d_read_ready", idx), instr_ready, 0);
        @(posedge clk); #1;
        check($sformatf("v%0d_exec_done", idx), done, 0);
        if (v.chk_ops) begin
            check($sformatf("v%0d_op1", idx), alu_op1, v.exp_op1);
            check($sformatf("v%0d_op2", idx), alu_op2, v.exp_op2);
        end
        @(posedge clk); #1;
        check($sformatf("v%0d_wb_done", idx), done, 1);
        check($sformatf("v%0d_wb_illegal", idx), illegal, v.exp_ill);
        @(posedge clk); #1;
        check($sformatf("v%0d_post_done", idx), done, 0);
        check($sformatf("v%0d_post_ready", idx), instr_ready, 1);
        dbg_addr = v.addr;
        #1;
        check($sformatf("v%0d_dbg_r%0d", idx, v.addr), dbg_data, v.exp_data);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        instr_valid = 1'b0;
        instr       = 16'h0000;
        dbg_addr    = 3'd0;

        vecs[0]  = '{mk_li(3'd1, 8'h05),            3'd1, 8'h05, 1'b0, 1'b0, 8'h00, 8'h00};
        vecs[1]  = '{mk_li(3'd2, 8'h03),            3'd2, 8'h03, 1'b0, 1'b0, 8'h00, 8'h00};
        vecs[2]  = '{mk_r(3'd0, 3'd3, 3'd1, 3'd2),  3'd3, 8'h08, 1'b0, 1'b1, 8'h05, 8'h03};
        vecs[3]  = '{mk_r(3'd1, 3'd4, 3'd2, 3'd1),  3'd4, 8'hFE, 1'b0, 1'b1, 8'h03, 8'h05};
        vecs[4]  = '{mk_li(3'd1, 8'hFF),            3'd1, 8'hFF, 1'b0, 1'b0, 8'h00, 8'h00};
        vecs[5]  = '{mk_li(3'd2, 8'h01),            3'd2, 8'h01, 1'b0, 1'b0, 8'h00, 8'h00};
        vecs[6]  = '{mk_r(3'd0, 3'd5, 3'd1, 3'd2),  3'd5, 8'h00, 1'b0, 1'b1, 8'hFF, 8'h01};
        vecs[7]  = '{mk_li(3'd6, 8'hF0),            3'd6, 8'hF0, 1'b0, 1'b0, 8'h00, 8'h00};
        vecs[8]  = '{mk_li(3'd7, 8'h3C),            3'd7, 8'h3C, 1'b0, 1'b0, 8'h00, 8'h00};
        vecs[9]  = '{mk_r(3'd2, 3'd3, 3'd6, 3'd7),  3'd3, 8'h30, 1'b0, 1'b1, 8'hF0, 8'h3C};
        vecs[10] = '{mk_r(3'd3, 3'd4, 3'd6, 3'd7),  3'd4, 8'hFC, 1'b0, 1'b1, 8'hF0, 8'h3C};
        vecs[11] = '{mk_r(3'd4, 3'd5, 3'd6, 3'd7),  3'd5, 8'hCC, 1'b0, 1'b1, 8'hF0, 8'h3C};
        vecs[12] = '{mk_r(3'd5, 3'd3, 3'd6, 3'd7),  3'd3, 8'h30, 1'b1, 1'b1, 8'hF0, 8'h3C};
        vecs[13] = '{mk_li(3'd0, 8'hAA),            3'd0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00};
        vecs[14] = '{mk_r(3'd6, 3'd1, 3'd2, 3'd3),  3'd1, 8'hFF, 1'b1, 1'b1, 8'h01, 8'h30};
        vecs[15] = '{mk_r(3'd1, 3'd2, 3'd0, 3'd2),  3'd2, 8'hFF, 1'b0, 1'b1, 8'h00, 8'h01};

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_ready", instr_ready, 1);
        check("rst_done", done, 0);
        check("rst_illegal", illegal, 0);
        check("rst_op1", alu_op1, 0);
        check("rst_op2", alu_op2, 0);
        check("rst_func", alu_func, 0);
        dbg_addr = 3'd1;
        #1;
        check("rst_dbg_r1", dbg_data, 0);

        for (int i = 0; i < 16; i++) begin
            run_vec(vecs[i], i);
        end

        // Continuous valid: accepts at k=0,4,8 only; r1 ends with 0x28.
        dbg_addr = 3'd1;
        for (int k = 0; k < 12; k++) begin
            instr       = mk_li(3'd1, 8'(8'h20 + k));
            instr_valid = 1'b1;
            check($sformatf("thru_ready_k%0d", k), instr_ready, (k % 4) == 0);
            check($sformatf("thru_done_k%0d", k), done, (k % 4) == 3);
            if (k == 4) check("thru_r1_k4", dbg_data, 8'h20);
            if (k == 8) check("thru_r1_k8", dbg_data, 8'h24);
            @(posedge clk); #1;
        end
        instr_valid = 1'b0;
        check("thru_r1_end", dbg_data, 8'h28);

        // Reset during EXEC of ADD r6 = r1 + r7.
        wait_ready();
        instr       = mk_r(3'd0, 3'd6, 3'd1, 3'd7);
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk); #1;
        check("abort_exec_op1", alu_op1, 8'h28);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_done", done, 0);
        check("abort_ready", instr_ready, 1);
        check("abort_op1", alu_op1, 0);
        check("abort_func", alu_func, 0);
        for (int a = 0; a < 8; a++) begin
            dbg_addr = 3'(a);
            #1;
            check($sformatf("abort_r%0d", a), dbg_data, 0);
        end
        @(posedge clk); #1;
        check("abort_done_after", done, 0);
        dbg_addr = 3'd6;
        #1;
        check("abort_r6_after", dbg_data, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
